cpu_datapath: RTL

- Datapath stage directly downstream of the control unit. Consumes the control unit's strobes and bus selects and produces ir_data back to it.
- Holds the 8-bit instruction pointer (IP), the 16-bit instruction register (IR) and a 16x16 general-purpose register file (GPR).
- Drives the address and data buses to the 256x16 program/data SRAM.

---
 rtl/cpu_datapath.sv | 99 +++++++++
 1 files changed

// File: rtl/cpu_datapath.sv
// Datapath behind the control unit: IP, IR and GPR file, plus the SRAM
// address/data buses and the write guard that prevents bus contention.
module cpu_datapath #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8,
  parameter int NREGS  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              reset_internal,
  input  logic [1:0]        data_select,
  input  logic [1:0]        address_select,
  input  logic              sram_en,
  input  logic              write_en,
  input  logic              ir_load,
  input  logic              gpr_load,
  input  logic              ip_increment,
  input  logic [3:0]        ra,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] ir_data,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_ce_n,
  output logic              mem_we_n,
  output logic [ADDR_W-1:0] ip,
  output logic [15:0]       retired,
  output logic              ip_wrap
);

  logic [ADDR_W-1:0] r_ip;
  logic [DATA_W-1:0] r_ir;
  logic [DATA_W-1:0] r_gpr [NREGS];
  logic [15:0]       r_retired;
  logic              r_ip_wrap;
  logic              r_ip_inc_q;

  logic [DATA_W-1:0] w_gpr_rd;
  logic [DATA_W-1:0] w_dbus;
  logic              w_advance;

  assign w_gpr_rd  = r_gpr[ra];
  assign w_advance = ip_increment && !r_ip_inc_q;

  always_comb begin
    w_dbus = '0;
    case (data_select)
      2'b00:   w_dbus = mem_rdata;
      2'b01:   w_dbus = w_gpr_rd;
      default: w_dbus = '0;
    endcase
  end

  always_comb begin
    mem_addr = '1;
    case (address_select)
      2'b00:   mem_addr = r_ip;
      2'b01:   mem_addr = address;
      default: mem_addr = '1;
    endcase
  end

  assign mem_wdata = w_gpr_rd;
  assign mem_ce_n  = reset ? 1'b1 : sram_en;
  // Only a GPR-sourced bus may be driven onto the SRAM, otherwise the
  // memory and the datapath would fight over the same wires.
  assign mem_we_n  = reset ? 1'b1 :
                     !(!write_en && !sram_en && (data_select == 2'b01));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ip       <= '0;
      r_ir       <= '0;
      r_retired  <= '0;
      r_ip_wrap  <= 1'b0;
      r_ip_inc_q <= 1'b0;
      for (int i = 0; i < NREGS; i++) r_gpr[i] <= '0;
    end else if (!reset_internal) begin
      r_ip       <= '0;
      r_ir       <= '0;
      r_ip_inc_q <= 1'b0;
    end else begin
      r_ip_inc_q <= ip_increment;
      if (ir_load)  r_ir      <= w_dbus;
      if (gpr_load) r_gpr[ra] <= w_dbus;
      if (w_advance) begin
        r_ip <= r_ip + 1'b1;
        if (r_ip == '1) r_ip_wrap <= 1'b1;
        if (r_retired != 16'hFFFF) r_retired <= r_retired + 16'd1;
      end
    end
  end

  assign ir_data = r_ir;
  assign ip      = r_ip;
  assign retired = r_retired;
  assign ip_wrap = r_ip_wrap;

endmodule
